// File: rtl/register_dump_reader.sv
// Walks a register file read port from index 0 to NUM_REGS-1 and streams each
// register out as an (index, value) word over a valid/ready handshake.
module register_dump_reader #(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] readReg,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  dumpValid,
  input  logic                  dumpReady,
  output logic [ADDR_WIDTH-1:0] dumpAddr,
  output logic [DATA_WIDTH-1:0] dumpData,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] index;
  logic [ADDR_WIDTH-1:0] index_next;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  at_last;

  assign at_last = (index == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = READ;
      READ:    state_next = PRESENT;
      PRESENT: begin
        if (dumpReady) begin
          state_next = at_last ? DONE : READ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The index only advances below the last register, so it never wraps even
  // when NUM_REGS fills the whole address space.
  always_comb begin
    index_next = index;
    if (state == IDLE && start) begin
      index_next = '0;
    end else if (state == PRESENT && dumpReady && !at_last) begin
      index_next = index + 1'b1;
    end
  end

  // The word is captured only in READ, so a stalled word stays frozen even if
  // the register file changes underneath it.
  always_ff @(posedge clock) begin
    if (reset) begin
      index     <= '0;
      word_addr <= '0;
      word_data <= '0;
    end else begin
      index <= index_next;
      if (state == READ) begin
        word_addr <= index;
        word_data <= readData;
      end
    end
  end

  always_comb begin
    readReg   = index;
    dumpAddr  = word_addr;
    dumpData  = word_data;
    dumpValid = (state == PRESENT);
    busy      = (state != IDLE);
    done      = (state == DONE);
  end

endmodule

// File: doc/register_dump_reader.md
# register_dump_reader

Sequential reader that walks the register file's read port and streams every register out as (index, value) words over a valid/ready handshake. It sits beside `Registers` on the `readReg1`/`readData1` read port and is the read-side counterpart of the write path. It gives the testbench and debug logic a cycle-accurate register snapshot without touching `$readmemb` files or hierarchical references. Writes through `RegWrite`/`writeReg`/`writeData` are never driven by this block.

## Interface
- `NUM_REGS`, default 32: registers dumped, indices 0..NUM_REGS-1; legal range 1..2^ADDR_WIDTH.
- `ADDR_WIDTH`, default 5: register index width.
- `DATA_WIDTH`, default 32: register data width.

Ports:
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `start` input 1: dump request, sampled while idle.
- `readReg` output ADDR_WIDTH: index driven to the register file read port.
- `readData` input DATA_WIDTH: combinational register file output for `readReg`, valid in the same cycle.
- `dumpValid` output 1: `dumpAddr`/`dumpData` hold a word.
- `dumpReady` input 1: consumer accepts the word.
- `dumpAddr` output ADDR_WIDTH: index of the presented word.
- `dumpData` output DATA_WIDTH: value of the presented word.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the last word is accepted.

## Operation
- FSM states:
  - IDLE: `start`=1 → READ, index counter cleared to 0; otherwise stay.
  - READ: `readReg`=index; at the edge, `dumpData`←`readData` and `dumpAddr`←index; → PRESENT.
  - PRESENT: `dumpValid`=1.
    - `dumpReady`=0: stay.
    - `dumpReady`=1 and index=NUM_REGS-1: → DONE.
    - `dumpReady`=1 otherwise: index+1 → READ.
  - DONE: `done`=1; → IDLE unconditionally.
- Reset values: state IDLE, index 0, `readReg`=0, `dumpAddr`=0, `dumpData`=0, `dumpValid`=0, `busy`=0, `done`=0.
- `readReg` always equals the index register (registered output, never glitching from the FSM decode).
- Index counter is ADDR_WIDTH bits. It only increments below NUM_REGS-1, so it never wraps. With NUM_REGS=2^ADDR_WIDTH the last index is all-ones and no overflow occurs.
- `start` while `busy`=1 is ignored and is not queued. `start` in the DONE cycle is ignored.
- Handshake rules:
  - While `dumpValid`=1 and `dumpReady`=0, `dumpValid`, `dumpAddr` and `dumpData` stay stable even if `readData` changes.
  - `dumpValid` never drops without acceptance, except on `reset`.
- Snapshot semantics: each word is the value of `readData` in that word's READ cycle. A register written after its READ cycle is not re-read. Cross-register consistency is the caller's responsibility (stall writes while `busy`).
- Reset mid-dump: FSM returns to IDLE on the next edge, all outputs take reset values, and no `done` pulse is produced. A new `start` restarts from index 0.
- `reset` and `start` in the same cycle: reset wins.

## Timing
- `start` sampled high at edge E0: READ in cycle 1, first `dumpValid` in cycle 2.
- Each word costs 2 cycles (READ + PRESENT), plus 1 cycle per extra cycle `dumpReady` is held low.
- With `dumpReady` tied high and NUM_REGS=32:
  - word k valid in cycle 2+2k; last word in cycle 64.
  - `done` in cycle 65; IDLE in cycle 66, where a new `start` is accepted.
- `done` and `dumpValid` are never high in the same cycle.

## Test plan
- Preload regs[k]=32'h1000_0000+k, hold `dumpReady`=1, pulse `start` → 32 words, addr 0..31 and data 32'h1000_0000..32'h1000_001F, in order; `dumpValid` in cycles 2,4,…,64; `done` only in cycle 65.
- Same preload, `dumpReady` low for 3 cycles on word 5 → `dumpAddr`=5 and `dumpData`=32'h1000_0005 held stable for 4 cycles; no word lost or duplicated; `done` 3 cycles later than in the first test.
- Pulse `start` again at word 10 and in the DONE cycle → no restart and no extra words; exactly 32 words and one `done` pulse.
- Assert `reset` while word 12 is presented → next cycle `busy`=0, `dumpValid`=0, `readReg`=0, `dumpData`=0, no `done`; a following `start` dumps from addr 0.
- Write regs[20]=32'hDEAD_BEEF via `RegWrite` during word 3's PRESENT → dumped word 20 = 32'hDEAD_BEEF. Write regs[2]=32'hCAFE_F00D during the same window → dumped word 2 keeps its preload value.
- NUM_REGS=4 → words for addr 0..3 only; `done` in cycle 9 after `start`.
